// File: rtl/dec_sync_ctrl_pkg.sv
// dec_sync_pkg: shared types and constants for the dec_sync_ctrl slice.
//   sync_state_t  : link-sync FSM states (LOS, ACQ, SYNC)
//   K28_5_BYTE    : decoded value of the K28.5 comma
//   ERR_CNT_W     : width of the saturating error counter
//   ONES_*        : popcount classes of a 10-bit symbol for disparity tracking
//   popcount10    : number of ones in a raw 10-bit symbol
package dec_sync_pkg;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_t;

    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam int         ERR_CNT_W  = 16;

    localparam logic [3:0] ONES_BALANCED = 4'd5;
    localparam logic [3:0] ONES_RD_POS   = 4'd6;
    localparam logic [3:0] ONES_RD_NEG   = 4'd4;

    function automatic logic [3:0] popcount10(input logic [9:0] s);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, s[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dec_sync_ctrl_if.sv
// dec_sync_ctrl_if: symbol/decoder/status bundle of the link-sync controller.
//   sym_valid, sym_in                 : raw 10-bit symbol stream (bit9 sent first)
//   dec_data, dec_k, dec_code_err,
//   dec_disp_err                      : decoder outputs, one cycle after sym_in
//   rdisp_out                         : running disparity fed to the decoder
//   bitslip                           : one-cycle slip request to the deserializer
//   sync_ok                           : link is in SYNC
//   out_valid, out_data, out_k        : qualified decoded symbol
//   err_cnt_clr, err_cnt              : saturating error counter and its clear
//   comma_cnt, los_cnt                : statistics, only with DEC_SYNC_STATS_EN
// Modports: slave = controller side, master = environment side.
interface dec_sync_ctrl_if;
    import dec_sync_pkg::*;

    logic                 sym_valid;
    logic [9:0]           sym_in;
    logic [7:0]           dec_data;
    logic                 dec_k;
    logic                 dec_code_err;
    logic                 dec_disp_err;
    logic                 rdisp_out;
    logic                 bitslip;
    logic                 sync_ok;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_k;
    logic                 err_cnt_clr;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef DEC_SYNC_STATS_EN
    logic [15:0]          comma_cnt;
    logic [7:0]           los_cnt;
`endif

    modport slave (
        input  sym_valid, sym_in, dec_data, dec_k, dec_code_err, dec_disp_err,
        input  err_cnt_clr,
        output rdisp_out, bitslip, sync_ok, out_valid, out_data, out_k, err_cnt
`ifdef DEC_SYNC_STATS_EN
        , output comma_cnt, los_cnt
`endif
    );

    modport master (
        output sym_valid, sym_in, dec_data, dec_k, dec_code_err, dec_disp_err,
        output err_cnt_clr,
        input  rdisp_out, bitslip, sync_ok, out_valid, out_data, out_k, err_cnt
`ifdef DEC_SYNC_STATS_EN
        , input comma_cnt, los_cnt
`endif
    );

endinterface

// File: rtl/dec_sync_ctrl_rd_tracker.sv
// dec_rd_tracker: running-disparity register driven from raw 10-bit symbols.
//   clk, rst   : clock, synchronous active-high reset
//   sym_valid  : sym_in is a real symbol this cycle
//   sym_in     : raw symbol
//   force_neg  : hold disparity at RD- (used while the deserializer settles after a slip)
//   rd         : disparity applied to the current sym_in (0 = RD-, 1 = RD+)
module dec_rd_tracker
    import dec_sync_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_valid,
    input  logic [9:0] sym_in,
    input  logic       force_neg,
    output logic       rd
);

    logic [3:0] ones;

    assign ones = popcount10(sym_in);

    // Only 4- and 6-ones symbols flip disparity; illegal counts are left to the decoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= 1'b0;
        end else if (force_neg) begin
            rd <= 1'b0;
        end else if (sym_valid) begin
            case (ones)
                ONES_RD_POS:   rd <= 1'b1;
                ONES_RD_NEG:   rd <= 1'b0;
                ONES_BALANCED: rd <= rd;
                default:       rd <= rd;
            endcase
        end
    end

endmodule

// File: rtl/dec_sync_ctrl.sv
// dec_sync_ctrl: link-synchronisation controller behind the 10b8b decoder.
// Tracks running disparity, qualifies decoder output, acquires/loses comma
// sync, requests bit-slips while unaligned and counts decode errors.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dec_sync_ctrl_if.slave (symbol in, decoder results, status out)
// Optional: define DEC_SYNC_STATS_EN to add comma_cnt and los_cnt statistics.
module dec_sync_ctrl
    import dec_sync_pkg::*;
#(
    parameter int COMMA_CNT = 3,
    parameter int SLIP_WAIT = 20,
    parameter int SLIP_HOLD = 4,
    parameter int MAX_BAD   = 4,
    parameter int GOOD_CNT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    dec_sync_ctrl_if.slave bus
);

    localparam logic [7:0] SCNT_LAST = 8'(SLIP_WAIT - 1);
    localparam logic [2:0] CCNT_DONE = 3'(COMMA_CNT);
    localparam logic [2:0] BCNT_DROP = 3'(MAX_BAD);
    localparam logic [3:0] GCNT_DONE = 4'(GOOD_CNT);
    localparam logic [3:0] HOLD_LOAD = 4'(SLIP_HOLD);

    sync_state_t          state, state_nxt;
    logic [7:0]           scnt, scnt_nxt;
    logic [2:0]           ccnt, ccnt_nxt;
    logic [2:0]           bcnt, bcnt_nxt;
    logic [3:0]           gcnt, gcnt_nxt;
    logic [3:0]           hold, hold_nxt;
    logic                 v1;
    logic                 slip_nxt, bitslip_q;
    logic                 out_valid_nxt, out_valid_q;
    logic [7:0]           out_data_q;
    logic                 out_k_q;
    logic [ERR_CNT_W-1:0] err_q, err_nxt;
    logic                 hold_active, comma, bad, err_inc;

    assign hold_active = (hold != 4'd0);

    // v1 marks the cycle in which the decoder shows the result of a symbol we accepted.
    assign comma = v1 & bus.dec_k & (bus.dec_data == K28_5_BYTE) & ~bus.dec_code_err;
    assign bad   = v1 & (bus.dec_code_err | bus.dec_disp_err);

    dec_rd_tracker u_rd (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (bus.sym_valid),
        .sym_in    (bus.sym_in),
        .force_neg (hold_active),
        .rd        (bus.rdisp_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOS;
            scnt        <= 8'd0;
            ccnt        <= 3'd0;
            bcnt        <= 3'd0;
            gcnt        <= 4'd0;
            hold        <= 4'd0;
            v1          <= 1'b0;
            bitslip_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_k_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state       <= state_nxt;
            scnt        <= scnt_nxt;
            ccnt        <= ccnt_nxt;
            bcnt        <= bcnt_nxt;
            gcnt        <= gcnt_nxt;
            hold        <= hold_nxt;
            v1          <= bus.sym_valid & ~hold_active;
            bitslip_q   <= slip_nxt;
            out_valid_q <= out_valid_nxt;
            if (out_valid_nxt) begin
                out_data_q <= bus.dec_data;
                out_k_q    <= bus.dec_k;
            end
            err_q       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        scnt_nxt      = scnt;
        ccnt_nxt      = ccnt;
        bcnt_nxt      = bcnt;
        gcnt_nxt      = gcnt;
        slip_nxt      = 1'b0;
        hold_nxt      = hold_active ? (hold - 4'd1) : 4'd0;
        out_valid_nxt = v1 & ~bad & (state == SYNC);

        case (state)
            LOS: begin
                if (comma) begin
                    scnt_nxt = 8'd0;
                    ccnt_nxt = 3'd1;
                    // With a single-comma requirement the first comma already locks.
                    if (CCNT_DONE == 3'd1) begin
                        state_nxt = SYNC;
                        bcnt_nxt  = 3'd0;
                        gcnt_nxt  = 4'd0;
                    end else begin
                        state_nxt = ACQ;
                    end
                end else if (v1) begin
                    if (scnt == SCNT_LAST) begin
                        slip_nxt = 1'b1;
                        scnt_nxt = 8'd0;
                        hold_nxt = HOLD_LOAD;
                    end else begin
                        scnt_nxt = scnt + 8'd1;
                    end
                end
            end
            ACQ: begin
                if (bad) begin
                    state_nxt = LOS;
                    scnt_nxt  = 8'd0;
                end else if (comma) begin
                    if (ccnt + 3'd1 == CCNT_DONE) begin
                        state_nxt = SYNC;
                        bcnt_nxt  = 3'd0;
                        gcnt_nxt  = 4'd0;
                    end else begin
                        ccnt_nxt = ccnt + 3'd1;
                    end
                end
            end
            SYNC: begin
                if (bad) begin
                    gcnt_nxt = 4'd0;
                    if (bcnt + 3'd1 == BCNT_DROP) begin
                        state_nxt = LOS;
                        scnt_nxt  = 8'd0;
                        bcnt_nxt  = 3'd0;
                    end else begin
                        bcnt_nxt = bcnt + 3'd1;
                    end
                end else if (v1) begin
                    // A full window of good symbols forgives one earlier error.
                    if (gcnt + 4'd1 == GCNT_DONE) begin
                        gcnt_nxt = 4'd0;
                        if (bcnt != 3'd0) begin
                            bcnt_nxt = bcnt - 3'd1;
                        end
                    end else begin
                        gcnt_nxt = gcnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = LOS;
            end
        endcase
    end

    // Clear wins over increment but still records an error arriving in the same cycle.
    always_comb begin
        err_inc = bad & ~hold_active;
        err_nxt = err_q;
        if (bus.err_cnt_clr) begin
            err_nxt = {{(ERR_CNT_W-1){1'b0}}, err_inc};
        end else if (err_inc && (err_q != '1)) begin
            err_nxt = err_q + 1'b1;
        end
    end

    assign bus.bitslip   = bitslip_q;
    assign bus.sync_ok   = (state == SYNC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_k     = out_k_q;
    assign bus.err_cnt   = err_q;

`ifdef DEC_SYNC_STATS_EN
    logic [15:0] comma_q;
    logic [7:0]  los_q;

    always_ff @(posedge clk) begin
        if (rst || bus.err_cnt_clr) begin
            comma_q <= 16'd0;
            los_q   <= 8'd0;
        end else begin
            if (comma && (comma_q != 16'hFFFF)) begin
                comma_q <= comma_q + 16'd1;
            end
            if ((state == SYNC) && (state_nxt == LOS) && (los_q != 8'hFF)) begin
                los_q <= los_q + 8'd1;
            end
        end
    end

    assign bus.comma_cnt = comma_q;
    assign bus.los_cnt   = los_q;
`endif

endmodule
